// File: rtl/kp_pkg.sv
// kpscan shared types and constants.
// Key map is indexed [row][col], rows top to bottom.
package kp_pkg;

  localparam int NROWS = 4;
  localparam int NCOLS = 4;

  typedef enum logic [1:0] {
    KP_SCAN,
    KP_DEBOUNCE,
    KP_HELD
  } kp_state_t;

  localparam logic [3:0] KEYMAP [NROWS][NCOLS] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

endpackage

// File: rtl/kp_sync.sv
// Parameterized-width 2-flop synchronizer.
// Reset value is programmable for inputs that idle high.
module kp_sync #(
  parameter int           W       = 4,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/kpscan.sv
// 4x4 keypad scanner with press/release debounce.
// Produces the hex code of the held key plus hit level and press strobe.
module kpscan
  import kp_pkg::*;
#(
  parameter int SCAN_DIV = 4096,
  parameter int DEBOUNCE = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] kpr,
  output logic [3:0] kpc,
  output logic [3:0] num,
  output logic       kphit,
  output logic       kpstrobe
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE);

  logic [3:0]    rows;
  kp_state_t     state_q;
  logic [1:0]    col_q;
  logic [1:0]    row_q;
  logic [DW-1:0] div_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    kpc_q;
  logic [3:0]    num_q;
  logic          hit_q;
  logic          stb_q;

  logic [1:0]    rsel;
  logic [1:0]    col_inc;
  logic          tick;
  logic          pressed;
  logic          last;
  logic          same;

  kp_sync #(
    .W      (4),
    .RST_VAL(4'hF)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (kpr),
    .q_o  (rows)
  );

  // Descending loop so the lowest low row wins.
  always_comb begin
    rsel = 2'd0;
    for (int i = NROWS - 1; i >= 0; i--) begin
      if (!rows[i]) rsel = 2'(i);
    end
  end

  assign pressed = ~&rows;
  assign same    = pressed && (rsel == row_q);
  assign last    = (cnt_q == CW'(DEBOUNCE - 1));
  assign tick    = (div_q == DW'(SCAN_DIV - 1));
  assign col_inc = col_q + 2'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= KP_SCAN;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      div_q   <= '0;
      cnt_q   <= '0;
      kpc_q   <= 4'b1110;
      num_q   <= 4'h0;
      hit_q   <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      stb_q <= 1'b0;
      div_q <= tick ? '0 : div_q + DW'(1);
      if (tick) begin
        unique case (state_q)
          KP_SCAN: begin
            if (pressed) begin
              row_q   <= rsel;
              cnt_q   <= CW'(1);
              state_q <= KP_DEBOUNCE;
            end else begin
              col_q <= col_inc;
              kpc_q <= ~(4'b0001 << col_inc);
            end
          end
          KP_DEBOUNCE: begin
            if (same && last) begin
              state_q <= KP_HELD;
              num_q   <= KEYMAP[row_q][col_q];
              hit_q   <= 1'b1;
              stb_q   <= 1'b1;
              cnt_q   <= '0;
            end else if (same) begin
              cnt_q <= cnt_q + CW'(1);
            end else begin
              state_q <= KP_SCAN;
              col_q   <= col_inc;
              kpc_q   <= ~(4'b0001 << col_inc);
            end
          end
          KP_HELD: begin
            if (!rows[row_q]) begin
              cnt_q <= '0;
            end else if (last) begin
              hit_q   <= 1'b0;
              state_q <= KP_SCAN;
              col_q   <= col_inc;
              kpc_q   <= ~(4'b0001 << col_inc);
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: state_q <= KP_SCAN;
        endcase
      end
    end
  end

  assign kpc      = kpc_q;
  assign num      = num_q;
  assign kphit    = hit_q;
  assign kpstrobe = stb_q;

endmodule

// File: doc/kpscan.md
# kpscan

4x4 matrix-keypad scanner and debouncer. It is the producer side of the 4-bit hex-code interface consumed by the seven-segment decoder.
- Drives keypad columns one at a time and samples the rows.
- Debounces press and release.
- Outputs the hex code of the held key, with a level `kphit` and a one-cycle `kpstrobe` per accepted press.

Sits between the board keypad pins and the display/control logic of the music player.

## Interface
- `SCAN_DIV`, 4096: clocks each column is driven before rows are sampled (settle time); must be ≥ 2.
- `DEBOUNCE`, 8: consecutive matching samples required to accept a press or a release; must be ≥ 2.
- `clk` input 1: single system clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `kpr` input 4: keypad rows, active-low, externally pulled up; asynchronous to `clk`.
- `kpc` output 4: keypad column drive, active-low, exactly one bit low at all times.
- `num` output 4: hex code of the last accepted key; holds after release.
- `kphit` output 1: high while an accepted key is held.
- `kpstrobe` output 1: one-cycle pulse on press acceptance.

## Operation
- `kpr` passes through a 2-flop synchronizer. Only the synchronized value is used.
- Divider `div` counts 0..SCAN_DIV-1 and wraps. `tick` is the cycle with `div == SCAN_DIV-1`. Rows are sampled only on `tick`.
- Column index `col` is 0..3; `kpc = ~(4'b0001 << col)`. `col` advances (3 wraps to 0) only where stated below.
- Pressed: any sampled row bit is 0. If several rows are low, the lowest row index wins.
- Key map, `num` value at [row][col], rows top to bottom:
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E (*), 0, F (#), D
- States: SCAN, DEBOUNCE, HELD.
- SCAN, on tick:
  - Pressed: latch `row`; `cnt <= 1`; go to DEBOUNCE. `col` is frozen.
  - Not pressed: `col++`.
- DEBOUNCE (col frozen), on tick:
  - Same row pressed and `cnt == DEBOUNCE-1`: go to HELD. `num <= map[row][col]`, `kphit <= 1`, `kpstrobe <= 1` for one cycle.
  - Same row pressed otherwise: `cnt++`.
  - Different row or no press: go to SCAN with `col++`.
- HELD (col frozen), on tick:
  - Latched row still low: `cnt <= 0`.
  - Latched row high and `cnt == DEBOUNCE-1`: `kphit <= 0`; go to SCAN with `col++`.
  - Latched row high otherwise: `cnt++`.
  - Other keys pressed in the same column are ignored.
- Counter widths: `div` is `$clog2(SCAN_DIV)` bits, `cnt` is `$clog2(DEBOUNCE)` bits. No overflow is possible because both are compared before incrementing.

## Timing
- Reset values (asynchronous):
  - Outputs: `num = 4'h0`, `kphit = 0`, `kpstrobe = 0`, `kpc = 4'b1110`.
  - Internal: `col = 0`, `div = 0`, `cnt = 0`, state SCAN, synchronizer flops `4'hF`.
- Reset asserted mid-operation: immediate return to reset values. No strobe is emitted on reset release.
- All outputs are registered. `kpc` changes the cycle after the tick on which `col` advances.
- Press latency: DEBOUNCE ticks from the first qualifying sample. `kphit` and `kpstrobe` rise on the edge of the DEBOUNCE-th tick.
- Release latency: DEBOUNCE consecutive high samples. `kphit` falls on the last of them.
- A bounce during DEBOUNCE restarts scanning. A bounce during HELD resets the release count.
- `kpstrobe` is never high for more than one cycle. A repeated press needs a full release first.

## Structure
- `kp_pkg` contains:
  - the state enum `kp_state_t` {SCAN, DEBOUNCE, HELD};
  - the constant `KEYMAP[4][4]` of 4-bit codes;
  - the `NROWS`/`NCOLS` = 4 constants.
- One sub-module, `kp_sync`: a parameterized-width 2-flop synchronizer with asynchronous active-high reset value. It is instantiated for `kpr`.

## Test plan
- Reset, no key, SCAN_DIV=4, DEBOUNCE=3:
  - `kpc` steps 1110→1101→1011→0111→1110, each held 4 cycles.
  - `kphit = 0` and `num = 0` throughout.
- Hold key '4' (kpr=1101 whenever kpc=1110) from reset:
  - `kphit` and `kpstrobe` rise on the 3rd tick (12th clock after reset release); `num = 4'h4`.
  - Strobe lasts one cycle; `kpc` stays 1110.
- Release '4' while HELD:
  - `kphit` falls after 3 high samples; `num` stays `4'h4`.
  - Column scanning resumes at 1101.
- Bounce on '#' (row3, col2) low for 1 tick then high:
  - No `kphit`, no strobe; scanning continues.
  - A later stable press yields `num = 4'hF`.
- Rows 0 and 2 both low in col 1:
  - Row 0 wins; `num = 4'h2`.
- Assert `reset` while HELD:
  - Outputs return to reset values asynchronously.
  - With the key still held after release of reset, re-acceptance takes a full DEBOUNCE period and produces exactly one strobe.
